// File: rtl/ddr_arbiter.sv
// Three-way DDRAM port arbiter: one burst writer, two burst readers.
// Define DDR_ARB_STATS_EN to add per-port burst and busy-cycle counters.
`timescale 1ns/1ps
module ddr_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
`ifdef DDR_ARB_STATS_EN
  input  logic                    stats_clear,
  output logic [15:0]             stats_w,
  output logic [15:0]             stats_r0,
  output logic [15:0]             stats_r1,
  output logic [31:0]             stats_busy,
`endif
  input  logic                    w_wr,
  input  logic [ADDR_WIDTH-1:0]   w_addr,
  input  logic [BURST_WIDTH-1:0]  w_burstLength,
  input  logic [DATA_WIDTH/8-1:0] w_mask,
  input  logic [DATA_WIDTH-1:0]   w_din,
  output logic                    w_waitReq,
  input  logic                    r0_rd,
  input  logic [ADDR_WIDTH-1:0]   r0_addr,
  input  logic [BURST_WIDTH-1:0]  r0_burstLength,
  output logic                    r0_waitReq,
  output logic                    r0_valid,
  output logic [DATA_WIDTH-1:0]   r0_dout,
  input  logic                    r1_rd,
  input  logic [ADDR_WIDTH-1:0]   r1_addr,
  input  logic [BURST_WIDTH-1:0]  r1_burstLength,
  output logic                    r1_waitReq,
  output logic                    r1_valid,
  output logic [DATA_WIDTH-1:0]   r1_dout,
  output logic                    ddr_rd,
  output logic                    ddr_wr,
  output logic [ADDR_WIDTH-1:0]   ddr_addr,
  output logic [BURST_WIDTH-1:0]  ddr_burstLength,
  output logic [DATA_WIDTH/8-1:0] ddr_mask,
  output logic [DATA_WIDTH-1:0]   ddr_din,
  input  logic [DATA_WIDTH-1:0]   ddr_dout,
  input  logic                    ddr_waitReq,
  input  logic                    ddr_valid
);

  typedef enum logic [1:0] {
    IDLE, READ_CMD, READ_DATA, WRITE
  } state_t;

  localparam logic [BURST_WIDTH-1:0] ONE = 1;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_owner;
  logic                   r_rr;
  logic [BURST_WIDTH-1:0] r_cnt;
  logic [BURST_WIDTH-1:0] r_burst;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic                   w_beat;
  logic                   w_done;
  logic                   w_pick_r1;

  function automatic logic [BURST_WIDTH-1:0] fix_len(
    input logic [BURST_WIDTH-1:0] b
  );
    return (b == '0) ? ONE : b;
  endfunction

  assign w_pick_r1       = r1_rd & (~r0_rd | r_rr);
  assign ddr_addr        = r_addr;
  assign ddr_burstLength = r_burst;
  assign r0_dout         = ddr_dout;
  assign r1_dout         = ddr_dout;

  always_comb begin
    w_state_nxt = r_state;
    ddr_rd      = 1'b0;
    ddr_wr      = 1'b0;
    ddr_din     = '0;
    ddr_mask    = '0;
    w_waitReq   = 1'b1;
    r0_waitReq  = 1'b1;
    r1_waitReq  = 1'b1;
    r0_valid    = 1'b0;
    r1_valid    = 1'b0;
    w_beat      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_wr)
          w_state_nxt = WRITE;
        else if (r0_rd | r1_rd)
          w_state_nxt = READ_CMD;
      end
      READ_CMD: begin
        ddr_rd = 1'b1;
        if (r_owner)
          r1_waitReq = ddr_waitReq;
        else
          r0_waitReq = ddr_waitReq;
        if (!ddr_waitReq)
          w_state_nxt = READ_DATA;
      end
      READ_DATA: begin
        r0_valid = ddr_valid & ~r_owner;
        r1_valid = ddr_valid & r_owner;
        w_beat   = ddr_valid;
      end
      WRITE: begin
        ddr_wr    = w_wr;
        ddr_din   = w_din;
        ddr_mask  = w_mask;
        w_waitReq = ddr_waitReq;
        w_beat    = w_wr & ~ddr_waitReq;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_done = w_beat & (r_cnt == r_burst - ONE);
    if (w_done)
      w_state_nxt = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_rr    <= 1'b0;
      r_cnt   <= '0;
      r_burst <= ONE;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE) begin
        r_cnt <= '0;
        if (w_wr) begin
          r_addr  <= w_addr;
          r_burst <= fix_len(w_burstLength);
        end else if (r0_rd | r1_rd) begin
          r_owner <= w_pick_r1;
          r_addr  <= w_pick_r1 ? r1_addr : r0_addr;
          r_burst <= fix_len(w_pick_r1 ? r1_burstLength
                                       : r0_burstLength);
        end
      end else if (w_done) begin
        r_cnt <= '0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + ONE;
      end
      // fairness only tracks readers; the writer always wins
      if (w_done && r_state == READ_DATA)
        r_rr <= ~r_owner;
    end
  end

`ifdef DDR_ARB_STATS_EN
  logic [15:0] r_st_w;
  logic [15:0] r_st_r0;
  logic [15:0] r_st_r1;
  logic [31:0] r_st_busy;

  always_ff @(posedge clock) begin
    if (reset || stats_clear) begin
      r_st_w    <= '0;
      r_st_r0   <= '0;
      r_st_r1   <= '0;
      r_st_busy <= '0;
    end else begin
      if (w_done && r_state == WRITE && r_st_w != 16'hFFFF)
        r_st_w <= r_st_w + 16'd1;
      if (w_done && r_state == READ_DATA && !r_owner &&
          r_st_r0 != 16'hFFFF)
        r_st_r0 <= r_st_r0 + 16'd1;
      if (w_done && r_state == READ_DATA && r_owner &&
          r_st_r1 != 16'hFFFF)
        r_st_r1 <= r_st_r1 + 16'd1;
      if (r_state != IDLE)
        r_st_busy <= r_st_busy + 32'd1;
    end
  end

  assign stats_w    = r_st_w;
  assign stats_r0   = r_st_r0;
  assign stats_r1   = r_st_r1;
  assign stats_busy = r_st_busy;
`endif

endmodule

// File: tb/tb_ddr_arbiter.sv
// Self-checking bench for ddr_arbiter: vector table, directed
// corner sequences and a randomized requester/DDR scoreboard.
`timescale 1ns/1ps
module tb_ddr_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int BW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          w_wr;
  logic [AW-1:0] w_addr;
  logic [BW-1:0] w_burstLength;
  logic [7:0]    w_mask;
  logic [DW-1:0] w_din;
  logic          w_waitReq;
  logic          r0_rd, r1_rd;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [BW-1:0] r0_burstLength, r1_burstLength;
  logic          r0_waitReq, r1_waitReq;
  logic          r0_valid, r1_valid;
  logic [DW-1:0] r0_dout, r1_dout;
  logic          ddr_rd, ddr_wr;
  logic [AW-1:0] ddr_addr;
  logic [BW-1:0] ddr_burstLength;
  logic [7:0]    ddr_mask;
  logic [DW-1:0] ddr_din;
  logic [DW-1:0] ddr_dout;
  logic          ddr_waitReq;
  logic          ddr_valid;
`ifdef DDR_ARB_STATS_EN
  logic          stats_clear;
  logic [15:0]   stats_w, stats_r0, stats_r1;
  logic [31:0]   stats_busy;
`endif

  ddr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                .BURST_WIDTH(BW)) dut (
    .clock(clock), .reset(reset),
`ifdef DDR_ARB_STATS_EN
    .stats_clear(stats_clear), .stats_w(stats_w),
    .stats_r0(stats_r0), .stats_r1(stats_r1),
    .stats_busy(stats_busy),
`endif
    .w_wr(w_wr), .w_addr(w_addr),
    .w_burstLength(w_burstLength), .w_mask(w_mask),
    .w_din(w_din), .w_waitReq(w_waitReq),
    .r0_rd(r0_rd), .r0_addr(r0_addr),
    .r0_burstLength(r0_burstLength),
    .r0_waitReq(r0_waitReq), .r0_valid(r0_valid),
    .r0_dout(r0_dout),
    .r1_rd(r1_rd), .r1_addr(r1_addr),
    .r1_burstLength(r1_burstLength),
    .r1_waitReq(r1_waitReq), .r1_valid(r1_valid),
    .r1_dout(r1_dout),
    .ddr_rd(ddr_rd), .ddr_wr(ddr_wr), .ddr_addr(ddr_addr),
    .ddr_burstLength(ddr_burstLength), .ddr_mask(ddr_mask),
    .ddr_din(ddr_din), .ddr_dout(ddr_dout),
    .ddr_waitReq(ddr_waitReq), .ddr_valid(ddr_valid)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        w, r0, r1;
    logic [7:0]  bw, b0, b1;
    logic        rd, wr;
    logic [31:0] addr;
    logic [7:0]  bl;
    logic        ww, w0, w1;
  } vec_t;
  vec_t vt[9];

  // random-phase model state
  logic        m_wact;
  int          m_wcnt, m_wlen;
  logic [31:0] m_wa;
  logic [7:0]  m_wraw;
  logic        m_ract[2];
  logic        m_rdat[2];
  logic [31:0] m_ra[2];
  logic [7:0]  m_rraw[2];
  int          m_rlen[2];
  int          m_done[3];
  logic        m_dp;
  int          m_own, m_dcnt;
  logic        acc0, acc1;
  int          pidx;
  logic        stopn;
  int          grants[$];
  int          wb, acc;
  logic        sched_wr[8];
  logic        sched_wt[8];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] fdat(input logic [31:0] a,
                                       input int k);
    return {a, 32'h5A00_0000 | 32'(k)} ^ 64'h0F0F_0000_0000_F0F0;
  endfunction

  function automatic logic [7:0] fmask(input logic [31:0] a,
                                       input int k);
    return a[11:4] ^ 8'(k * 37);
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    w_wr = 0; w_addr = 0; w_burstLength = 0;
    w_mask = 0; w_din = 0;
    r0_rd = 0; r0_addr = 0; r0_burstLength = 0;
    r1_rd = 0; r1_addr = 0; r1_burstLength = 0;
    ddr_dout = 0; ddr_waitReq = 0; ddr_valid = 0;
`ifdef DDR_ARB_STATS_EN
    stats_clear = 0;
`endif
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    cyc();
    cyc();
    reset = 0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk(nm, {ddr_rd, ddr_wr, ddr_addr, ddr_burstLength, ddr_mask,
             w_waitReq, r0_waitReq, r1_waitReq, r0_valid, r1_valid},
        {1'b0, 1'b0, 32'h0, 8'h1, 8'h0,
         1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
  endtask

  task automatic do_read(input int p, input logic [31:0] a,
                         input logic [7:0] bl, input string nm);
    int n, t;
    logic ok;
    n = (bl == 0) ? 1 : int'(bl);
    ddr_waitReq = 0;
    if (p == 0) begin
      r0_rd = 1; r0_addr = a; r0_burstLength = bl;
    end else begin
      r1_rd = 1; r1_addr = a; r1_burstLength = bl;
    end
    ok = 0;
    t = 0;
    while (!ok && t < 20) begin
      @(negedge clock);
      ok = (p == 0) ? (r0_rd & ~r0_waitReq) : (r1_rd & ~r1_waitReq);
      if (ok)
        chk({nm, "_cmd"}, {ddr_rd, ddr_addr, ddr_burstLength},
            {1'b1, a, 8'(n)});
      cyc();
      t++;
    end
    r0_rd = 0;
    r1_rd = 0;
    if (!ok) begin
      chk({nm, "_timeout"}, 0, 1);
      return;
    end
    for (int k = 0; k < n; k++) begin
      ddr_valid = 1;
      ddr_dout = fdat(a, k);
      @(negedge clock);
      if (p == 0)
        chk({nm, "_beat"}, {r0_valid, r1_valid, r0_dout},
            {1'b1, 1'b0, fdat(a, k)});
      else
        chk({nm, "_beat"}, {r1_valid, r0_valid, r1_dout},
            {1'b1, 1'b0, fdat(a, k)});
      cyc();
    end
    ddr_valid = 0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] bl,
                          input string nm);
    int n, a_cnt, t;
    n = (bl == 0) ? 1 : int'(bl);
    a_cnt = 0;
    t = 0;
    w_addr = a; w_burstLength = bl; ddr_waitReq = 0; w_wr = 1;
    while (a_cnt < n && t < 50) begin
      w_din = fdat(a, a_cnt);
      w_mask = fmask(a, a_cnt);
      @(negedge clock);
      if (w_wr && !w_waitReq) begin
        chk({nm, "_beat"}, {ddr_wr, ddr_addr, ddr_din},
            {1'b1, a, fdat(a, a_cnt)});
        a_cnt++;
      end
      cyc();
      t++;
    end
    w_wr = 0;
    chk({nm, "_done"}, a_cnt, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1,0,0, 4,0,0,   0,1, 32'hA000, 4,   0,1,1};
    vt[1] = '{0,1,0, 0,3,0,   1,0, 32'hB000, 3,   1,0,1};
    vt[2] = '{0,0,1, 0,0,5,   1,0, 32'hC000, 5,   1,1,0};
    vt[3] = '{0,1,1, 0,2,6,   1,0, 32'hB000, 2,   1,0,1};
    vt[4] = '{1,1,1, 7,2,2,   0,1, 32'hA000, 7,   0,1,1};
    vt[5] = '{1,0,1, 0,0,3,   0,1, 32'hA000, 1,   0,1,1};
    vt[6] = '{0,0,1, 0,0,0,   1,0, 32'hC000, 1,   1,1,0};
    vt[7] = '{0,0,0, 0,0,0,   0,0, 32'h0,    1,   1,1,1};
    vt[8] = '{0,1,0, 0,255,0, 1,0, 32'hB000, 255, 1,0,1};

    // reset state, including a stale DDR beat
    do_reset();
    ddr_valid = 1;
    @(negedge clock);
    chk_reset_vals("reset_vals");
    cyc();
    ddr_valid = 0;

    // first-grant vector table
    for (int i = 0; i < 9; i++) begin
      do_reset();
      w_wr = vt[i].w; w_addr = 32'hA000;
      w_burstLength = vt[i].bw; w_din = 64'h1234;
      r0_rd = vt[i].r0; r0_addr = 32'hB000;
      r0_burstLength = vt[i].b0;
      r1_rd = vt[i].r1; r1_addr = 32'hC000;
      r1_burstLength = vt[i].b1;
      @(negedge clock);
      chk($sformatf("vec%0d_idle", i),
          {w_waitReq, r0_waitReq, r1_waitReq, ddr_rd, ddr_wr},
          5'b11100);
      cyc();
      @(negedge clock);
      chk($sformatf("vec%0d", i),
          {ddr_rd, ddr_wr, ddr_addr, ddr_burstLength,
           w_waitReq, r0_waitReq, r1_waitReq},
          {vt[i].rd, vt[i].wr, vt[i].addr, vt[i].bl,
           vt[i].ww, vt[i].w0, vt[i].w1});
    end

    // single read, 4 beats
    do_reset();
    r0_rd = 1; r0_addr = 32'h1000; r0_burstLength = 4;
    @(negedge clock);
    chk("rd_c0", {ddr_rd, r0_waitReq}, 2'b01);
    cyc();
    @(negedge clock);
    chk("rd_cmd",
        {ddr_rd, ddr_addr, ddr_burstLength, r0_waitReq, r1_waitReq},
        {1'b1, 32'h1000, 8'd4, 1'b0, 1'b1});
    cyc();
    r0_rd = 0;
    for (int k = 0; k < 4; k++) begin
      ddr_valid = 1;
      ddr_dout = fdat(32'h1000, k);
      @(negedge clock);
      chk("rd_beat", {ddr_rd, r0_valid, r1_valid, r0_dout},
          {1'b0, 1'b1, 1'b0, fdat(32'h1000, k)});
      cyc();
    end
    @(negedge clock);
    chk("rd_after", {r0_valid, r1_valid, r0_waitReq}, 3'b001);
    cyc();
    ddr_valid = 0;

    // contention: W first, then alternating readers
    do_reset();
    w_wr = 1; w_addr = 32'hA000; w_burstLength = 2;
    w_din = fdat(32'hA000, 0);
    r0_rd = 1; r0_addr = 32'hB000; r0_burstLength = 2;
    r1_rd = 1; r1_addr = 32'hC000; r1_burstLength = 2;
    ddr_valid = 1; ddr_dout = 64'hDEAD;
    grants.delete();
    wb = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (w_wr && !w_waitReq) begin
        if (wb == 0) grants.push_back(0);
        chk("ct_wdata", ddr_din, fdat(32'hA000, wb));
        wb++;
      end
      if (ddr_rd && !r0_waitReq) begin
        grants.push_back(1);
        chk("ct_r0addr", ddr_addr, 32'hB000);
      end
      if (ddr_rd && !r1_waitReq) begin
        grants.push_back(2);
        chk("ct_r1addr", ddr_addr, 32'hC000);
      end
      cyc();
      if (wb >= 2) w_wr = 0;
      w_din = fdat(32'hA000, wb);
    end
    chk("ct_count", grants.size() >= 8, 1);
    for (int i = 0; i < 8; i++)
      if (i < grants.size())
        chk($sformatf("ct_order%0d", i), grants[i],
            (i == 0) ? 0 : ((i % 2 == 1) ? 1 : 2));
    r0_rd = 0; r1_rd = 0; ddr_valid = 0;

    // write with stalls and a mid-burst w_wr gap
    sched_wr = '{1, 1, 1, 1, 1, 1, 0, 1};
    sched_wt = '{1, 1, 0, 1, 1, 0, 0, 0};
    do_reset();
    w_wr = 1; w_addr = 32'h2000; w_burstLength = 3;
    @(negedge clock);
    chk("ws_idle0", w_waitReq, 1);
    cyc();
    acc = 0;
    for (int j = 0; j < 8; j++) begin
      w_wr = sched_wr[j];
      ddr_waitReq = sched_wt[j];
      w_din = fdat(32'h2000, acc);
      w_mask = fmask(32'h2000, acc);
      @(negedge clock);
      chk("ws_wait", {w_waitReq, ddr_wr, ddr_addr, ddr_burstLength},
          {sched_wt[j], sched_wr[j], 32'h2000, 8'd3});
      if (sched_wr[j])
        chk("ws_data", {ddr_din, ddr_mask},
            {fdat(32'h2000, acc), fmask(32'h2000, acc)});
      if (w_wr && !w_waitReq) acc++;
      cyc();
    end
    chk("ws_beats", acc, 3);
    w_wr = 0; ddr_waitReq = 0;
    @(negedge clock);
    chk("ws_idle", {w_waitReq, ddr_wr}, 2'b10);
    cyc();

    // burst length 0 on R1
    do_read(1, 32'h3000, 8'd0, "b0");
    ddr_valid = 1;
    @(negedge clock);
    chk("b0_done", {r1_valid, r0_valid}, 2'b00);
    cyc();
    ddr_valid = 0;

    // reset in the middle of an 8-beat read
    do_reset();
    r0_rd = 1; r0_addr = 32'h4000; r0_burstLength = 8;
    cyc();
    @(negedge clock);
    chk("rm_cmd", {ddr_rd, ddr_addr, r0_waitReq},
        {1'b1, 32'h4000, 1'b0});
    cyc();
    r0_rd = 0;
    for (int k = 0; k < 2; k++) begin
      ddr_valid = 1;
      ddr_dout = fdat(32'h4000, k);
      @(negedge clock);
      chk("rm_beat", r0_valid, 1);
      cyc();
    end
    reset = 1;
    cyc();
    reset = 0;
    ddr_valid = 1;
    @(negedge clock);
    chk_reset_vals("rm_reset");
    cyc();
    @(negedge clock);
    chk("rm_stale", {r0_valid, r1_valid}, 2'b00);
    cyc();
    ddr_valid = 0;
    do_read(1, 32'h5000, 8'd2, "rm_new");

    // randomized traffic against a transaction scoreboard
    do_reset();
    m_wact = 0; m_dp = 0;
    m_ract = '{0, 0}; m_rdat = '{0, 0};
    m_done = '{0, 0, 0};
    for (int c = 0; c < 4000; c++) begin
      stopn = (c >= 3000);
      if (!m_wact && !stopn && $urandom_range(0, 19) == 0) begin
        m_wact = 1;
        m_wa = $urandom() & 32'hFFFF_FFC0;
        m_wraw = 8'($urandom_range(0, 6));
        m_wlen = (m_wraw == 0) ? 1 : int'(m_wraw);
        m_wcnt = 0;
      end
      w_wr = m_wact && ($urandom_range(0, 3) != 0);
      w_addr = m_wact ? m_wa : $urandom();
      w_burstLength = m_wact ? m_wraw : 8'($urandom());
      w_din = fdat(m_wa, m_wcnt);
      w_mask = fmask(m_wa, m_wcnt);
      for (int i = 0; i < 2; i++)
        if (!m_ract[i] && !stopn && $urandom_range(0, 7) == 0) begin
          m_ract[i] = 1;
          m_rdat[i] = 0;
          m_ra[i] = $urandom() & 32'hFFFF_FFC0;
          m_rraw[i] = 8'($urandom_range(0, 6));
          m_rlen[i] = (m_rraw[i] == 0) ? 1 : int'(m_rraw[i]);
        end
      r0_rd = m_ract[0] && !m_rdat[0];
      r0_addr = m_ra[0]; r0_burstLength = m_rraw[0];
      r1_rd = m_ract[1] && !m_rdat[1];
      r1_addr = m_ra[1]; r1_burstLength = m_rraw[1];
      ddr_waitReq = ($urandom_range(0, 2) == 0);
      if (m_dp) begin
        ddr_valid = ($urandom_range(0, 2) != 0);
        ddr_dout = fdat(m_ra[m_own], m_dcnt);
      end else begin
        ddr_valid = ($urandom_range(0, 7) == 0);
        ddr_dout = {$urandom(), $urandom()};
      end
      @(negedge clock);
      chk("rnd_excl", ddr_rd & ddr_wr, 0);
      chk("rnd_whs", ddr_wr & ~ddr_waitReq, w_wr & ~w_waitReq);
      if (w_wr && !w_waitReq) begin
        chk("rnd_wbeat", {ddr_addr, ddr_burstLength, ddr_din, ddr_mask},
            {m_wa, 8'(m_wlen), fdat(m_wa, m_wcnt),
             fmask(m_wa, m_wcnt)});
        m_wcnt++;
        if (m_wcnt == m_wlen) begin
          m_wact = 0;
          m_done[0]++;
        end
      end
      if (m_dp && ddr_valid) begin
        chk("rnd_rvalid", {r0_valid, r1_valid},
            (m_own == 1) ? 2'b01 : 2'b10);
        chk("rnd_rdout", (m_own == 1) ? r1_dout : r0_dout,
            fdat(m_ra[m_own], m_dcnt));
        m_dcnt++;
        if (m_dcnt == m_rlen[m_own]) begin
          m_dp = 0;
          m_ract[m_own] = 0;
          m_rdat[m_own] = 0;
          m_done[1 + m_own]++;
        end
      end else begin
        chk("rnd_novalid", {r0_valid, r1_valid}, 2'b00);
      end
      acc0 = r0_rd & ~r0_waitReq;
      acc1 = r1_rd & ~r1_waitReq;
      chk("rnd_rhs", ddr_rd & ~ddr_waitReq, acc0 | acc1);
      chk("rnd_racc2", acc0 & acc1, 0);
      if (acc0 | acc1) begin
        pidx = acc1 ? 1 : 0;
        chk("rnd_rcmd", {ddr_addr, ddr_burstLength},
            {m_ra[pidx], 8'(m_rlen[pidx])});
        chk("rnd_rbusy", m_dp, 0);
        m_rdat[pidx] = 1;
        m_dp = 1;
        m_own = pidx;
        m_dcnt = 0;
      end
      cyc();
    end
    chk("rnd_drain", {m_wact, m_ract[0], m_ract[1]}, 3'b000);
    chk("rnd_wdone", m_done[0] > 0, 1);
    chk("rnd_r0done", m_done[1] > 0, 1);
    chk("rnd_r1done", m_done[2] > 0, 1);

`ifdef DDR_ARB_STATS_EN
    do_reset();
    @(negedge clock);
    chk("st_reset", {stats_w, stats_r0, stats_r1, stats_busy}, 0);
    cyc();
    for (int i = 0; i < 3; i++)
      do_write(32'h6000 + 32'(i * 64), 8'd1, "st_w");
    for (int i = 0; i < 5; i++)
      do_read(0, 32'h7000 + 32'(i * 64), 8'd1, "st_r0");
    @(negedge clock);
    chk("st_counts", {stats_w, stats_r0, stats_r1},
        {16'd3, 16'd5, 16'd0});
    chk("st_busy", stats_busy, 32'd13);
    cyc();
    stats_clear = 1;
    cyc();
    stats_clear = 0;
    @(negedge clock);
    chk("st_clear", {stats_w, stats_r0, stats_r1, stats_busy}, 0);
    cyc();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_arbiter.md
Name: ddr_arbiter

Overview:
- Shares the single DDRAM Avalon-style port between three requesters:
  - one burst writer (ROM download / frame buffer writer, port W);
  - two burst readers (R0, R1; e.g. frame buffer scan-out and tile/sprite fetch).
- Sits inside Main, between the requesters and the io_ddr_* pins in the fast clock domain.
- Holds a grant for one complete burst, then re-arbitrates.

Parameters:
- ADDR_WIDTH, 32, byte address width on all ports.
- DATA_WIDTH, 64, data width on all ports.
- BURST_WIDTH, 8, burst length field width.

Ports:
- clock  in  1  fast system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- w_wr  in  1  writer write request / beat valid.
- w_addr  in  ADDR_WIDTH  writer burst start address (sampled on first beat).
- w_burstLength  in  BURST_WIDTH  writer beats per burst.
- w_mask  in  DATA_WIDTH/8  writer byte enables.
- w_din  in  DATA_WIDTH  writer beat data.
- w_waitReq  out  1  writer stall.
- r0_rd, r1_rd  in  1  reader read requests.
- r0_addr, r1_addr  in  ADDR_WIDTH  read start addresses.
- r0_burstLength, r1_burstLength  in  BURST_WIDTH  read beats.
- r0_waitReq, r1_waitReq  out  1  reader command stall.
- r0_valid, r1_valid  out  1  read beat valid.
- r0_dout, r1_dout  out  DATA_WIDTH  read beat data.
- ddr_rd, ddr_wr  out  1  DDR commands.
- ddr_addr  out  ADDR_WIDTH  DDR address.
- ddr_burstLength  out  BURST_WIDTH  DDR burst count.
- ddr_mask  out  DATA_WIDTH/8  DDR byte enables.
- ddr_din  out  DATA_WIDTH  DDR write data.
- ddr_dout  in  DATA_WIDTH  DDR read data.
- ddr_waitReq  in  1  DDR busy.
- ddr_valid  in  1  DDR read data valid.

Behaviour:
- States:
  - IDLE, READ_CMD, READ_DATA, WRITE.
  - Register beat counter cnt (BURST_WIDTH bits).
  - Latched owner (R0/R1), latched addr and burst.
  - Round-robin pointer rr (0 = R0 preferred).
- Reset values:
  - state IDLE, rr=0, cnt=0.
  - ddr_rd=0, ddr_wr=0, ddr_addr=0, ddr_burstLength=1, ddr_mask=0.
  - all *_waitReq=1, all *_valid=0.
- IDLE arbitration, cycle N:
  - w_wr has priority over readers.
  - Else if exactly one reader requests, grant it.
  - Else if both request, grant R[rr].
  - Latch addr/burst of the winner in cycle N.
  - Next state is WRITE or READ_CMD at N+1.
  - A latched burst of 0 is coerced to 1.
- READ_CMD:
  - ddr_rd=1 with latched addr/burst.
  - Owner's waitReq = ddr_waitReq; non-owner waitReq=1.
  - When ddr_waitReq=0: go to READ_DATA, cnt=0.
  - Owner sees its rd accepted in that same cycle.
- READ_DATA:
  - ddr_rd=0.
  - r*_dout = ddr_dout combinationally on both ports.
  - Owner's valid = ddr_valid; non-owner valid=0.
  - Each valid beat increments cnt.
  - The beat with cnt == burst-1 returns to IDLE and sets rr to the non-owner.
- WRITE:
  - ddr_wr=w_wr, ddr_din=w_din, ddr_mask=w_mask.
  - ddr_addr/ddr_burstLength are the latched values.
  - w_waitReq = ddr_waitReq.
  - Beat accepted when w_wr & ~ddr_waitReq; cnt increments.
  - The accepted beat with cnt == burst-1 returns to IDLE.
  - Writer deasserting w_wr mid-burst is legal: no beat is counted and the grant is held.
- Outside the owning state, every requester sees waitReq=1, so no request is lost.
- Back-to-back:
  - Returning to IDLE costs one cycle.
  - A continuously requesting reader pair alternates R0,R1,R0…
- ddr_valid outside READ_DATA (e.g. stale beats after reset) is dropped; no r*_valid pulse.
- Reset mid-burst aborts immediately to reset values.
  - Requesters must reissue.
  - The DDR side is expected to be reset together.
- Starvation: readers can be starved only while W keeps requesting; download bursts are finite by design.

Optional Feature:
- Macro DDR_ARB_STATS_EN.
- With it defined, the block adds:
  - Input stats_clear.
  - Outputs stats_w, stats_r0, stats_r1 (16 bits each): completed bursts per port, saturating at 0xFFFF.
  - Output stats_busy (32 bits): cycles spent outside IDLE, wrapping.
  - All counters clear on reset or stats_clear; clear wins over a same-cycle increment.
- Without the macro, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Single read: r0_rd, addr 0x1000, burst 4; ddr_waitReq low.
  - ddr_rd=1 exactly one cycle after request, addr 0x1000, burstLength 4.
  - Four ddr_valid beats appear on r0_valid; r1_valid stays 0; IDLE after the 4th beat.
- Contention: r0_rd, r1_rd and w_wr asserted in the same cycle, burst 2 each.
  - Order of service: W, then R0, then R1.
  - Then with both readers held, grants continue R0, R1 alternately.
- Write stall: W burst 3 with ddr_waitReq high on beats 1 and 2 for 2 cycles each.
  - w_waitReq mirrors ddr_waitReq.
  - Exactly 3 accepted beats; data and mask pass through unchanged; then IDLE.
- Burst length 0 on R1: exactly one read beat accepted before returning to IDLE.
- Reset asserted mid READ_DATA after 2 of 8 beats.
  - Next cycle all outputs at reset values.
  - Stale ddr_valid pulses produce no r*_valid.
  - A subsequent new r1 request is served normally.
- With DDR_ARB_STATS_EN: 3 W bursts and 5 R0 bursts.
  - stats_w=3, stats_r0=5, stats_r1=0.
  - stats_clear returns all counters to 0.
